// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one handshaked word-bus access per instruction,
// with store lane alignment, load extension, alignment checks and a bus timeout.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [2:0]  mt_q;
    logic [1:0]  off_q;
    logic        ld_q;

    logic        access, is_st, bad_type, misaligned, illegal;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [7:0]  cnt_inc;
    logic        timed_out;

    // Request decode; a simultaneous load and store resolves to the store.
    always_comb begin
        access     = rd_en | wr_en;
        is_st      = wr_en;
        bad_type   = is_st ? (mem_type > 3'd2) : (mem_type > 3'd4);
        misaligned = 1'b0;
        case (mem_type)
            3'd1, 3'd4: misaligned = addr[0];
            3'd2:       misaligned = |addr[1:0];
            default:    misaligned = 1'b0;
        endcase
        illegal = bad_type | misaligned;

        case (mem_type[1:0])
            2'd0: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = wdata << {addr[1:0], 3'b000};
            end
            2'd1: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = wdata << {addr[1], 4'b0000};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (mt_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd3:    ld_ext = {24'b0, ld_byte};
            3'd4:    ld_ext = {16'b0, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        case (state)
            IDLE:    stall = access;
            REQ:     stall = 1'b1;
            WAIT:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign cnt_inc   = tmo_cnt + 8'd1;
    assign timed_out = (cnt_inc == TMO);

    // Timeout beats a same-cycle handshake so the counter never passes TMO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
            mt_q      <= '0;
            off_q     <= '0;
            ld_q      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (access) begin
                        if (illegal) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= is_st;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= is_st ? st_be : 4'b1111;
                            bus_wdata <= is_st ? st_data : 32'd0;
                            mt_q      <= mem_type;
                            off_q     <= addr[1:0];
                            ld_q      <= ~is_st;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= cnt_inc;
                    if (timed_out) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        err     <= 1'b1;
                        if (ld_q) rdata <= '0;
                    end else if (bus_gnt) begin
                        state   <= WAIT;
                        bus_req <= 1'b0;
                    end
                end
                WAIT: begin
                    tmo_cnt <= cnt_inc;
                    if (timed_out) begin
                        state <= DONE;
                        err   <= 1'b1;
                        if (ld_q) rdata <= '0;
                    end else if (bus_rvalid) begin
                        state <= DONE;
                        if (ld_q) rdata <= ld_ext;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: per-cycle expectations built from a transaction-level
// model of the access rules, checked on every falling edge.
module tb_lsu_mem_stage;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst, rd_en, wr_en, bus_gnt, bus_rvalid;
    logic [2:0]  mem_type;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    lsu_mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .mem_type(mem_type),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // One cycle: what the bench drives and what the outputs must show.
    typedef struct {
        bit          rd, wr, rs, gnt, rv;
        logic [31:0] bus_rd;
        bit          chk_bus, chk_st;
        logic        stall, req, we, err;
        logic [31:0] addr, wd, rdata;
        logic [3:0]  be;
    } cyc_t;

    cyc_t        exp_q[$];
    cyc_t        ce;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_rdata = 32'd0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(ce.stall));
            chk("bus_req", 32'(bus_req), 32'(ce.req));
            chk("err", 32'(err), 32'(ce.err));
            chk("rdata", rdata, ce.rdata);
            if (ce.chk_bus) begin
                chk("bus_addr", bus_addr, ce.addr);
                chk("bus_we", 32'(bus_we), 32'(ce.we));
                if (ce.chk_st) begin
                    chk("bus_be", 32'(bus_be), 32'(ce.be));
                    chk("bus_wdata", bus_wdata, ce.wd);
                end
            end
        end
    end

    function automatic cyc_t blank();
        cyc_t c;
        c.rd = 0; c.wr = 0; c.rs = 0; c.gnt = 0; c.rv = 0; c.bus_rd = 32'h0;
        c.chk_bus = 0; c.chk_st = 0; c.stall = 0; c.req = 0; c.we = 0; c.err = 0;
        c.addr = 32'h0; c.wd = 32'h0; c.rdata = m_rdata; c.be = 4'h0;
        return c;
    endfunction

    // Access width in bytes for a mem_type code.
    function automatic int size_of(logic [2:0] mt);
        case (mt)
            3'd0, 3'd3: return 1;
            3'd1, 3'd4: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit legal_f(bit st, logic [2:0] mt, logic [31:0] a);
        if (st ? (mt > 3'd2) : (mt > 3'd4)) return 0;
        return (a % size_of(mt)) == 0;
    endfunction

    // Shift the addressed item to the top, then shift back down with or without sign.
    function automatic logic [31:0] load_f(logic [2:0] mt, logic [31:0] a, logic [31:0] word);
        int          sh;
        logic [31:0] v;
        sh = 32 - 8 * size_of(mt);
        v  = (word >> (8 * (a % 4))) << sh;
        if (mt < 3'd3) return 32'($signed(v) >>> sh);
        return v >> sh;
    endfunction

    task automatic drive(cyc_t c);
        @(posedge clk);
        #1;
        rd_en = c.rd; wr_en = c.wr; rst = c.rs;
        bus_gnt = c.gnt; bus_rvalid = c.rv; bus_rdata = c.bus_rd;
        exp_q.push_back(c);
    endtask

    // g: REQ cycles before gnt (<0 never); r: WAIT cycles before rvalid.
    task automatic txn(bit rd, bit wr, logic [2:0] mt, logic [31:0] a, logic [31:0] wd,
                       int g, int r, logic [31:0] word, bit rst_in_wait);
        cyc_t c;
        bit   st, tmo;
        int   k, w, n;
        st = wr; tmo = 0;
        n  = size_of(mt);
        mem_type = mt; addr = a; wdata = wd;
        c = blank();
        c.rd = rd; c.wr = wr; c.bus_rd = ~word; c.stall = 1;
        drive(c);
        if (!legal_f(st, mt, a)) begin
            c.stall = 0; c.err = 1;
            drive(c);
        end else begin
            k   = (g < 0 || g + 1 >= T) ? T : g + 1;
            tmo = (k == T) || (k + r + 1 >= T);
            w   = tmo ? T - k : r + 1;
            c.req = 1; c.chk_bus = 1; c.chk_st = st; c.we = st;
            c.addr = {a[31:2], 2'b00};
            c.be = 4'(((1 << n) - 1) << (a % 4));
            c.wd = wd << (8 * (a % 4));
            for (int i = 0; i < k; i++) begin
                c.gnt = (g >= 0 && i == g);
                drive(c);
            end
            c.req = 0; c.chk_bus = 0; c.gnt = 0;
            for (int j = 0; j < w; j++) begin
                c.rv = (!tmo && j == r);
                c.bus_rd = c.rv ? word : ~word;
                if (rst_in_wait) begin
                    c.rs = 1;
                    drive(c);
                    m_rdata = 32'd0;
                    c = blank();
                    c.chk_bus = 1; c.chk_st = 1;
                    drive(c);
                    return;
                end
                drive(c);
            end
            c.rv = 0; c.bus_rd = ~word; c.stall = 0; c.err = tmo;
            if (!st) m_rdata = tmo ? 32'd0 : load_f(mt, a, word);
            c.rdata = m_rdata;
            drive(c);
        end
        // Two idle cycles; after a timeout a late gnt/rvalid arrives and must be ignored.
        for (int i = 0; i < 2; i++) begin
            c = blank();
            c.gnt = tmo; c.rv = tmo; c.bus_rd = 32'h1234_5678;
            drive(c);
        end
    endtask

    task automatic lit(string name, logic [31:0] exp);
        chk(name, rdata, exp);
    endtask

    initial begin
        rst = 1; rd_en = 0; wr_en = 0; bus_gnt = 0; bus_rvalid = 0;
        mem_type = 3'd0; addr = 32'd0; wdata = 32'd0; bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        ce = blank();
        ce.chk_bus = 1; ce.chk_st = 1;
        drive(ce);

        txn(0, 1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, 0);       // SB lane 3
        txn(1, 0, 3'd2, 32'h0000_2000, 32'h0, 0, 0, 32'h80FF_7F01, 0);       // LW
        lit("lw_lit", 32'h80FF_7F01);
        txn(1, 0, 3'd0, 32'h0000_2002, 32'h0, 1, 1, 32'h80FF_7F01, 0);       // LB
        lit("lb_lit", 32'hFFFF_FFFF);
        txn(1, 0, 3'd3, 32'h0000_2002, 32'h0, 0, 2, 32'h80FF_7F01, 0);       // LBU
        lit("lbu_lit", 32'h0000_00FF);
        txn(1, 0, 3'd1, 32'h0000_2002, 32'h0, 0, 0, 32'h80FF_7F01, 0);       // LH
        lit("lh_lit", 32'hFFFF_80FF);
        txn(1, 0, 3'd4, 32'h0000_2002, 32'h0, 2, 0, 32'h80FF_7F01, 0);       // LHU
        lit("lhu_lit", 32'h0000_80FF);
        txn(1, 0, 3'd2, 32'h0000_0102, 32'h0, 0, 0, 32'h0, 0);               // misaligned LW
        lit("illegal_keeps_rdata", 32'h0000_80FF);
        txn(0, 1, 3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 3, 0, 32'h0, 0);       // SW, gnt late
        txn(0, 1, 3'd1, 32'h0000_3006, 32'h1234_ABCD, 0, 1, 32'h0, 0);       // SH upper
        txn(1, 1, 3'd0, 32'h0000_4001, 32'h0000_0011, 0, 0, 32'h5555_5555, 0); // both -> SB
        lit("store_keeps_rdata", 32'h0000_80FF);
        txn(0, 1, 3'd3, 32'h0000_4000, 32'h0, 0, 0, 32'h0, 0);               // bad store type
        txn(1, 0, 3'd4, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 0);               // misaligned LHU
        txn(1, 0, 3'd0, 32'h0000_5001, 32'h0, 0, 0, 32'h0000_8000, 0);       // LB offset 1
        lit("lb_off1_lit", 32'hFFFF_FF80);
        txn(1, 0, 3'd1, 32'h0000_6000, 32'h0, 0, 10, 32'h1111_2222, 0);      // timeout in WAIT
        lit("wait_tmo_lit", 32'h0);
        txn(1, 0, 3'd3, 32'h0000_2003, 32'h0, 0, 0, 32'h80FF_7F01, 0);       // LBU -> 0x80
        txn(1, 0, 3'd2, 32'h0000_5000, 32'h0, -1, 0, 32'hAAAA_AAAA, 0);      // timeout in REQ
        lit("req_tmo_lit", 32'h0);
        txn(1, 0, 3'd2, 32'h0000_2000, 32'h0, 0, 0, 32'h80FF_7F01, 0);       // restore rdata
        txn(1, 0, 3'd2, 32'h0000_7000, 32'h0, 0, 3, 32'h9999_9999, 1);       // reset in WAIT
        txn(0, 1, 3'd2, 32'h0000_7004, 32'hCAFE_F00D, 0, 0, 32'h0, 0);       // SW after reset

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
